// File: rtl/rom_socket_flash_initiator.sv
// Host initiator: maps MODE/WRITE/READ/PROGRAM requests onto ROM-socket read cycles.
// Define ROM_ADDR_CACHE_EN to skip LO/MID/BANK cycles that repeat the last value sent.
module rom_socket_flash_initiator #(
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int GAP    = 1
) (
  input  logic        fast_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rom_ce_n,
  output logic        rom_oe_n
);
  localparam int TOTAL = SETUP + STROBE + GAP;
  localparam int PW = $clog2(TOTAL + 1);
  localparam logic [PW-1:0] PH_ON  = PW'(SETUP - 1);
  localparam logic [PW-1:0] PH_OFF = PW'(SETUP + STROBE - 1);
  localparam logic [PW-1:0] PH_END = PW'(TOTAL - 1);

  localparam logic [1:0] CMD_MODE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd2;
  localparam logic [1:0] CMD_PROG = 2'd3;
  localparam logic [14:0] RD_WORD = 15'h0600;

  typedef enum logic [2:0] {IDLE, ENTER, ADDR, DATA, DONE} state_t;

  function automatic logic [14:0] enter_word(
    input logic [2:0] i,
    input logic       f
  );
    case (i)
      3'd0:    enter_word = 15'h0555;
      3'd1:    enter_word = 15'h0AAA;
      3'd2:    enter_word = 15'h0555;
      3'd3:    enter_word = 15'h02AA;
      default: enter_word = {14'd0, f};
    endcase
  endfunction

  function automatic logic [14:0] addr_word(
    input logic [1:0]  i,
    input logic [18:0] a
  );
    case (i)
      2'd0:    addr_word = {4'd0, 3'd0, a[7:0]};
      2'd1:    addr_word = {4'd0, 3'd1, a[15:8]};
      default: addr_word = {4'd0, 3'd2, 5'd0, a[18:16]};
    endcase
  endfunction

  // Step 3 is the caller's own address; 0..2 are the JEDEC unlock writes.
  function automatic logic [18:0] raw_a(
    input logic [1:0]  s,
    input logic [18:0] a
  );
    case (s)
      2'd1:    raw_a = 19'h02AAA;
      2'd3:    raw_a = a;
      default: raw_a = 19'h05555;
    endcase
  endfunction

  function automatic logic [7:0] raw_d(
    input logic [1:0] s,
    input logic [7:0] d
  );
    case (s)
      2'd0:    raw_d = 8'hAA;
      2'd1:    raw_d = 8'h55;
      2'd2:    raw_d = 8'hA0;
      default: raw_d = d;
    endcase
  endfunction

  // First address cycle at or after start that must be issued; 3 = none left.
  function automatic logic [1:0] first_idx(
    input logic [1:0] start,
    input logic [2:0] hit_v
  );
    first_idx = 2'd3;
    for (int i = 2; i >= 0; i--)
      if (2'(i) >= start && !hit_v[i]) first_idx = 2'(i);
  endfunction

  state_t        st;
  logic [2:0]    idx;
  logic [1:0]    step;
  logic [1:0]    cmd_q;
  logic [PW-1:0] ph;
  logic [18:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rd_q;
  logic          flag_q;
  logic          mode_q;

  logic [1:0]    t_cmd;
  logic [1:0]    t_step;
  logic [18:0]   t_a;
  logic [7:0]    t_d;
  logic [18:0]   tgt_a;
  logic [1:0]    nidx;
  logic [14:0]   nword;
  logic [2:0]    hit;
  logic          last;

  assign last = (ph == PH_END);

  always_comb begin
    t_cmd  = cmd_q;
    t_step = step;
    t_a    = addr_q;
    t_d    = wdata_q;
    if (st == IDLE) begin
      t_cmd  = req_cmd;
      t_step = (req_cmd == CMD_PROG) ? 2'd0 : 2'd3;
      t_a    = req_addr;
      t_d    = req_wdata;
    end else if (st == DATA) begin
      t_step = step + 2'd1;
    end
    tgt_a = raw_a(t_step, t_a);
    nidx  = first_idx((st == ADDR) ? idx[1:0] + 2'd1 : 2'd0, hit);
    if (nidx == 2'd3)
      nword = (t_cmd == CMD_READ) ? RD_WORD
                                  : {4'd0, 3'd7, raw_d(t_step, t_d)};
    else
      nword = addr_word(nidx, tgt_a);
  end

`ifdef ROM_ADDR_CACHE_EN
  logic [14:0] c_lo;
  logic [14:0] c_mid;
  logic [14:0] c_bank;
  logic        c_v;

  always_comb begin
    hit[0] = c_v && (c_lo   == addr_word(2'd0, tgt_a));
    hit[1] = c_v && (c_mid  == addr_word(2'd1, tgt_a));
    hit[2] = c_v && (c_bank == addr_word(2'd2, tgt_a));
  end

  // Unlock cycles land on the bridge's BANK/LO latches, so ENTER invalidates.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      c_v    <= 1'b0;
      c_lo   <= '0;
      c_mid  <= '0;
      c_bank <= '0;
    end else if (st == ENTER) begin
      c_v <= 1'b0;
    end else if (st == ADDR) begin
      case (idx[1:0])
        2'd0:    c_lo <= rom_addr;
        2'd1:    c_mid <= rom_addr;
        default: begin
          c_bank <= rom_addr;
          c_v    <= 1'b1;
        end
      endcase
    end
  end
`else
  assign hit = 3'b000;
`endif

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      st        <= IDLE;
      idx       <= '0;
      step      <= '0;
      cmd_q     <= '0;
      ph        <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      flag_q    <= 1'b0;
      mode_q    <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rom_addr  <= '0;
      rom_ce_n  <= 1'b1;
      rom_oe_n  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (st == ENTER || st == ADDR || st == DATA) begin
        ph <= ph + 1'b1;
        if (ph == PH_ON) begin
          rom_ce_n <= 1'b0;
          rom_oe_n <= 1'b0;
        end
        if (ph == PH_OFF) begin
          rom_ce_n <= 1'b1;
          rom_oe_n <= 1'b1;
          if (st == DATA) rd_q <= rom_data;
        end
      end
      unique case (st)
        IDLE: if (req_valid && req_ready) begin
          cmd_q     <= req_cmd;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          step      <= t_step;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          ph        <= '0;
          if (req_cmd == CMD_MODE || !mode_q) begin
            st       <= ENTER;
            idx      <= '0;
            rom_addr <= enter_word(3'd0, 1'b0);
            flag_q   <= (req_cmd == CMD_MODE) ? req_wdata[0] : 1'b1;
          end else begin
            st       <= (nidx == 2'd3) ? DATA : ADDR;
            idx      <= {1'b0, nidx};
            rom_addr <= nword;
          end
        end
        ENTER: if (last) begin
          ph <= '0;
          if (idx != 3'd4) begin
            idx      <= idx + 3'd1;
            rom_addr <= enter_word(idx + 3'd1, flag_q);
          end else begin
            mode_q <= flag_q;
            if (cmd_q == CMD_MODE) begin
              st <= DONE;
            end else begin
              st       <= (nidx == 2'd3) ? DATA : ADDR;
              idx      <= {1'b0, nidx};
              rom_addr <= nword;
            end
          end
        end
        ADDR: if (last) begin
          ph       <= '0;
          st       <= (nidx == 2'd3) ? DATA : ADDR;
          idx      <= {1'b0, nidx};
          rom_addr <= nword;
        end
        DATA: if (last) begin
          if (step != 2'd3) begin
            step     <= step + 2'd1;
            ph       <= '0;
            st       <= (nidx == 2'd3) ? DATA : ADDR;
            idx      <= {1'b0, nidx};
            rom_addr <= nword;
          end else begin
            st <= DONE;
          end
        end
        DONE: begin
          st        <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= (cmd_q == CMD_READ) ? rd_q : 8'h00;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
